universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//   Parameterised universal shift register: hold, shift right, shift left or
//   parallel load, selected per clock by a 2-bit mode. General-purpose
//   datapath building block (serial/parallel conversion, bit alignment).
//   One register stage; output is the register contents directly.
// PARAMETERS
//   WIDTH  4  register / data width in bits (legal range >= 2)
// PORTS
//   clk   in   1      single clock; all state updates on rising edge
//   rst   in   1      asynchronous, active-low reset (0 = reset asserted)
//   MODE  in   2      operation select, sampled at rising edge of clk
//   din   in   WIDTH  parallel load data; also supplies serial-in bits
//   dout  out  WIDTH  current register contents (registered output)
// BEHAVIOUR
//   - Reset: rst=0 forces dout=0 immediately (no clock needed) and holds it
//     while low. Release of rst takes effect at the next rising clk edge.
//   - At each rising clk edge with rst=1, the next state is set by MODE:
//       2'b00 HOLD   : dout <= dout
//       2'b01 SHR    : dout <= {din[WIDTH-1], dout[WIDTH-1:1]}
//                      (MSB takes serial-in din[WIDTH-1]; bit 0 discarded)
//       2'b10 SHL    : dout <= {dout[WIDTH-2:0], din[0]}
//                      (LSB takes serial-in din[0]; MSB discarded)
//       2'b11 LOAD   : dout <= din
//   - Latency: one clock from MODE/din sample to dout update; no handshake.
//   - MODE with X/Z bits: treat as HOLD (default branch), never corrupt state.
//   - Reset mid-operation: asynchronous clear wins over any mode. The first
//     edge after release executes the MODE present at that edge.
//   - No wrap-around: shifted-out bits are lost; they are not rotated.
//   - All other din bits are don't-care in SHR/SHL/HOLD.
// STRUCTURE
//   - Shared package usr_pkg: localparams MODE_HOLD=2'b00, MODE_SHR=2'b01,
//     MODE_SHL=2'b10, MODE_LOAD=2'b11.
//   - Optional sub-module usr_bit_cell: a 4:1 mux plus flop per bit
//     (inputs: hold, right-neighbour, left-neighbour, parallel). Instantiate
//     WIDTH copies with generate; edge cells take the serial-in bits.
//     A flat always_ff with case on MODE is an equally acceptable implementation.
// TESTING
//   1. rst=0 at any point, din=1010, MODE=11 -> dout=0000 immediately and
//      stays 0000 across edges while rst=0.
//   2. rst=1, MODE=11, din=1010 -> dout=1010 after 1 edge; then MODE=00
//      -> dout holds 1010 for 3 edges regardless of din changes.
//   3. From 0000, MODE=10, din=0111 (din[0]=1) -> 0001, 0011, 0111, 1111
//      on successive edges.
//   4. From 0000, MODE=01, din=1000 (din[3]=1) -> 1000, 1100, 1110, 1111;
//      then din=0000 -> 0111, 0011.
//   5. From 1010, MODE=10, din[0]=0 -> 0100, 1000, 0000 (no rotate).
//   6. Mid-shift (dout=0011), pull rst low between edges -> dout=0000
//      before the next edge; release rst with MODE=11, din=0101 -> 0101
//      after the next edge.

Source files
------------

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encodings for the universal shift register
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - one register bit: 4:1 mode mux feeding a flop
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       par_in,
  output logic       q
);

  logic d;

  // Unknown or unlisted mode values fall to hold so state is never corrupted
  always_comb begin
    d = q;
    case (mode)
      MODE_HOLD: d = q;
      MODE_SHR:  d = shr_in;
      MODE_SHL:  d = shl_in;
      MODE_LOAD: d = par_in;
      default:   d = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - hold / shift right / shift left / load register
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Edge cells take serial-in from din; shifted-out bits are dropped, not rotated
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shr_src;
    logic shl_src;

    if (i == WIDTH - 1) begin : g_msb
      assign shr_src = din[WIDTH-1];
    end else begin : g_mid_r
      assign shr_src = dout[i+1];
    end

    if (i == 0) begin : g_lsb
      assign shl_src = din[0];
    end else begin : g_mid_l
      assign shl_src = dout[i-1];
    end

    usr_bit_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .mode   (MODE),
      .shr_in (shr_src),
      .shl_in (shl_src),
      .par_in (din[i]),
      .q      (dout[i])
    );
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed-vector bench for universal_shift_reg
module tb_universal_shift_reg;

  logic       clk;
  logic       rst;
  logic [1:0] MODE;
  logic [3:0] din;
  logic [3:0] dout;

  int vectors;
  int miscompares;

  universal_shift_reg #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .MODE (MODE),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: dout=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply mode/din, let one rising edge pass, then sample 1ns later
  task automatic step(input logic [1:0] m, input logic [3:0] d, input logic [3:0] exp, input string tag);
    MODE = m;
    din  = d;
    @(posedge clk);
    #1;
    check(tag, dout, exp);
  endtask

  logic [3:0] shl_fill [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [3:0] shr_fill [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
  logic [3:0] shl_drop [3] = '{4'b0100, 4'b1000, 4'b0000};
  logic [3:0] hold_din [3] = '{4'b0000, 4'b1111, 4'b0101};

  initial begin
    vectors     = 0;
    miscompares = 0;

    rst  = 1'b0;
    MODE = 2'b11;
    din  = 4'b1010;
    #2;
    check("reset_async", dout, 4'b0000);
    @(posedge clk); #1;
    check("reset_hold_e1", dout, 4'b0000);
    @(posedge clk); #1;
    check("reset_hold_e2", dout, 4'b0000);

    rst = 1'b1;
    step(2'b11, 4'b1010, 4'b1010, "load_1010");
    for (int i = 0; i < 3; i++)
      step(2'b00, hold_din[i], 4'b1010, $sformatf("hold_%0d", i));

    for (int i = 0; i < 3; i++)
      step(2'b10, 4'b0110, shl_drop[i], $sformatf("shl_norotate_%0d", i));

    for (int i = 0; i < 4; i++)
      step(2'b10, 4'b0111, shl_fill[i], $sformatf("shl_fill_%0d", i));

    #2;
    rst = 1'b0;
    #1;
    check("reset_midcycle", dout, 4'b0000);
    rst = 1'b1;

    for (int i = 0; i < 4; i++)
      step(2'b01, 4'b1000, shr_fill[i], $sformatf("shr_fill_%0d", i));
    step(2'b01, 4'b0000, 4'b0111, "shr_zero_0");
    step(2'b01, 4'b0000, 4'b0011, "shr_zero_1");

    MODE = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    check("reset_midshift", dout, 4'b0000);
    MODE = 2'b11;
    din  = 4'b0101;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("release_load", dout, 4'b0101);

    step(2'b10, 4'b1110, 4'b1010, "shl_after_release");
    step(2'b01, 4'b0111, 4'b0101, "shr_din_msb0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
